// File: rtl/round_reset_sequencer.sv
// Round-reset controller: merges NUM_SRC requests into a held board reset followed by a start pulse.
// Optional macro ROUND_RESET_RETRIGGER_EN lets requests during the hold restart the hold window.
module round_reset_sequencer #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               hardResetN,
  input  logic [NUM_SRC-1:0] req,
  output logic               roundReset,
  output logic               roundStart,
  output logic [NUM_SRC-1:0] cause,
  output logic [CNT_W-1:0]   roundCount
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               start_q, start_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Hard reset enters HOLD so the board sees a full reset window after release.
  always_ff @(posedge clk) begin
    if (!hardResetN) begin
      state_q <= StHold;
      cnt_q   <= HoldLoad;
      start_q <= 1'b0;
      cause_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    cause_d = cause_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
          cause_d = req;
          count_d = count_q + CNT_W'(1);
        end
      end
      StHold: begin
`ifdef ROUND_RESET_RETRIGGER_EN
        if (|req) begin
          cnt_d   = HoldLoad;
          cause_d = cause_q | req;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StIdle;
          start_d = 1'b1;
        end
`else
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StIdle;
          start_d = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    roundReset = (state_q == StHold);
    roundStart = start_q;
    cause      = cause_q;
    roundCount = count_q;
  end

endmodule
